// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencer that serially loads a WIDTH-bit bidirectional shift register.
// Latency: start sampled at edge k -> SHIFT k+1..k+WIDTH, CAPTURE k+WIDTH+1, done in cycle k+WIDTH+2.
// Backpressure: start is ignored while busy (no queueing); a start in DONE is accepted back-to-back.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   start, dir_left   - request a load; direction for it (1 = left/MSB first, 0 = right/LSB first)
//   din               - word to serialise, latched with start
//   sh_q              - current shift register contents
//   sh_en, sh_left,
//   sh_in             - shift enable, direction and serial bit to the datapath
//   busy, done, dout  - busy in SHIFT/CAPTURE, one-cycle done pulse, captured word
//   abort             - only when SHIFT_SEQ_CTRL_ABORT_EN is defined: cancel a running sequence
//
// Optional feature macro: SHIFT_SEQ_CTRL_ABORT_EN

module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir_left,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] sh_q,
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             sh_en,
  output logic             sh_left,
  output logic             sh_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] tx;     // shadow of the word being serialised
  logic [CNT_W-1:0] cnt;    // bits already sent in this sequence
  logic             dir_r;  // latched direction, so dir_left may change mid-sequence

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic abort_hit;
  assign abort_hit = abort && ((state == SHIFT) || (state == CAPTURE));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx    <= '0;
      cnt   <= '0;
      dir_r <= 1'b0;
      dout  <= '0;
    end else begin
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
      // Abort drops straight to IDLE; dout keeps the last completed capture.
      if (abort_hit) begin
        state <= IDLE;
      end else
`endif
      begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              tx    <= din;
              dir_r <= dir_left;
              cnt   <= '0;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
          SHIFT: begin
            // Move the next bit to the end that sh_in reads from.
            tx  <= dir_r ? (tx << 1) : (tx >> 1);
            // Counter saturates at LAST: the sequence leaves SHIFT on that edge.
            if (cnt == LAST) begin
              state <= CAPTURE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          CAPTURE: begin
            // Last shift landed on the previous edge, so sh_q is final here.
            dout  <= sh_q;
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Outputs decode the state register and registered shadows only.
  assign sh_en   = (state == SHIFT);
  assign sh_left = dir_r;
  assign sh_in   = (state == SHIFT) ? (dir_r ? tx[WIDTH-1] : tx[0]) : 1'b0;
  assign busy    = (state == SHIFT) || (state == CAPTURE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl with a behavioural 4-bit shift register datapath.
// Expected words and serial bits are queued at start and popped when the DUT produces them.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir_left;
  logic [3:0] din;
  logic [3:0] sh_q;
  logic       sh_en, sh_left, sh_in, busy, done;
  logic [3:0] dout;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic       abort;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [3:0] exp_q[$];
  logic       exp_bits[$];

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir_left (dir_left),
    .din      (din),
    .sh_q     (sh_q),
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    .abort    (abort),
`endif
    .sh_en    (sh_en),
    .sh_left  (sh_left),
    .sh_in    (sh_in),
    .busy     (busy),
    .done     (done),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: left q[i-1]->q[i], in->q[0]; right q[i+1]->q[i], in->q[3].
  always @(posedge clk or posedge rst) begin
    if (rst) sh_q <= 4'b0000;
    else if (sh_en) sh_q <= sh_left ? {sh_q[2:0], sh_in} : {sh_in, sh_q[3:1]};
  end

  // Called at a falling edge with the DUT in IDLE or DONE; returns the cycle count of the accepting edge.
  task automatic start_seq(input logic [3:0] d, input logic left, output int k);
    start    = 1'b1;
    din      = d;
    dir_left = left;
    exp_q.push_back(d);
    for (int i = 0; i < 4; i++) exp_bits.push_back(left ? d[3-i] : d[i]);
    @(negedge clk);
    start = 1'b0;
    k     = cyc;
  endtask

  // Collects sh_in on enabled cycles until done (bounded); optionally fires start with junk while shifting.
  task automatic observe(input bit noise, output logic [7:0] bits, output int n,
                         output int dcyc, output logic [3:0] dv, output logic [3:0] qv);
    bits = '0; n = 0; dcyc = -1; dv = '0; qv = '0;
    for (int t = 0; t < 30; t++) begin
      if (done) begin
        dcyc = cyc; dv = dout; qv = sh_q;
        break;
      end
      if (sh_en && n < 8) begin
        bits[n] = sh_in;
        n++;
      end
      if (noise) begin
        start    = sh_en;
        din      = 4'b1111;
        dir_left = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({sh_en, sh_left, sh_in, busy, done} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 00000", {sh_en, sh_left, sh_in, busy, done});
    end
    tests++;
    if (dout !== 4'b0000) begin
      fails++; $display("FAIL reset_dout: got %b want 0000", dout);
    end
  endtask

  task automatic test_load(input string name, input logic [3:0] d, input logic left);
    int k, n, dcyc;
    logic [7:0] bits;
    logic [3:0] dv, qv, ed;
    logic eb;
    start_seq(d, left, k);
    observe(1'b0, bits, n, dcyc, dv, qv);
    ed = exp_q.pop_front();
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL %s_en_cycles: got %0d want 4", name, n);
    end
    for (int i = 0; i < 4; i++) begin
      eb = exp_bits.pop_front();
      tests++;
      if (bits[i] !== eb) begin
        fails++; $display("FAIL %s_sh_in[%0d]: got %b want %b", name, i, bits[i], eb);
      end
    end
    tests++;
    if (dcyc !== k + 5) begin
      fails++; $display("FAIL %s_done_latency: got %0d want %0d", name, dcyc - k, 5);
    end
    tests++;
    if (dv !== ed) begin
      fails++; $display("FAIL %s_dout: got %b want %b", name, dv, ed);
    end
    tests++;
    if (qv !== ed) begin
      fails++; $display("FAIL %s_sh_q: got %b want %b", name, qv, ed);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL %s_done_single: got %b want 0", name, done);
    end
  endtask

  task automatic test_busy_ignore;
    int k, n, dcyc, extra;
    logic [7:0] bits;
    logic [3:0] dv, qv, ed;
    start_seq(4'b0001, 1'b0, k);
    observe(1'b1, bits, n, dcyc, dv, qv);
    ed = exp_q.pop_front();
    for (int i = 0; i < 4; i++) void'(exp_bits.pop_front());
    tests++;
    if (dv !== ed) begin
      fails++; $display("FAIL busy_ignore_dout: got %b want %b", dv, ed);
    end
    extra = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++; $display("FAIL busy_ignore_extra_activity: got %0d cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int k1, nd, d1, d2;
    logic [3:0] v1, v2, e1, e2;
    nd = 0; d1 = -1; d2 = -1; v1 = '0; v2 = '0;
    start = 1'b1; din = 4'b1100; dir_left = 1'b1;
    exp_q.push_back(4'b1100);
    @(negedge clk);
    k1 = cyc;
    din = 4'b0011; dir_left = 1'b0;  // must not disturb the running sequence
    exp_q.push_back(4'b0011);
    for (int t = 0; t < 40 && nd < 2; t++) begin
      if (done) begin
        if (nd == 0) begin d1 = cyc; v1 = dout; end
        else begin d2 = cyc; v2 = dout; end
        nd++;
      end else if (nd >= 1) begin
        start = 1'b0;
      end
      if (nd < 2) @(negedge clk);
    end
    start = 1'b0;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    tests++;
    if (nd !== 2) begin
      fails++; $display("FAIL b2b_done_count: got %0d want 2", nd);
    end
    tests++;
    if (d1 !== k1 + 5) begin
      fails++; $display("FAIL b2b_first_latency: got %0d want 5", d1 - k1);
    end
    tests++;
    if (d2 - d1 !== 6) begin
      fails++; $display("FAIL b2b_done_spacing: got %0d want 6", d2 - d1);
    end
    tests++;
    if (v1 !== e1) begin
      fails++; $display("FAIL b2b_dout1: got %b want %b", v1, e1);
    end
    tests++;
    if (v2 !== e2) begin
      fails++; $display("FAIL b2b_dout2: got %b want %b", v2, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int k;
    start_seq(4'b1011, 1'b1, k);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({sh_en, sh_left, sh_in, busy, done} !== 5'b0) begin
      fails++; $display("FAIL reset_mid_outputs: got %b want 00000", {sh_en, sh_left, sh_in, busy, done});
    end
    tests++;
    if (dout !== 4'b0000) begin
      fails++; $display("FAIL reset_mid_dout: got %b want 0000", dout);
    end
    exp_q.delete();
    exp_bits.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({sh_en, busy, done} !== 3'b0) begin
      fails++; $display("FAIL reset_mid_idle: got %b want 000", {sh_en, busy, done});
    end
  endtask

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  task automatic test_abort;
    int k, n, dcyc, nd;
    logic [7:0] bits;
    logic [3:0] dv, qv, ed;
    start_seq(4'b0101, 1'b0, k);
    observe(1'b0, bits, n, dcyc, dv, qv);
    ed = exp_q.pop_front();
    for (int i = 0; i < 4; i++) void'(exp_bits.pop_front());
    tests++;
    if (dv !== ed) begin
      fails++; $display("FAIL abort_prior_dout: got %b want %b", dv, ed);
    end
    @(negedge clk);
    start_seq(4'b1010, 1'b1, k);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({sh_en, busy} !== 2'b00) begin
      fails++; $display("FAIL abort_drop: got %b want 00", {sh_en, busy});
    end
    nd = 0;
    for (int t = 0; t < 10; t++) begin
      if (done) nd++;
      @(negedge clk);
    end
    tests++;
    if (nd !== 0) begin
      fails++; $display("FAIL abort_no_done: got %0d want 0", nd);
    end
    tests++;
    if (dout !== 4'b0101) begin
      fails++; $display("FAIL abort_dout_kept: got %b want 0101", dout);
    end
    exp_q.delete();
    exp_bits.delete();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; dir_left = 1'b0; din = 4'b0000;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_load("left", 4'b1011, 1'b1);
    test_load("right", 4'b0110, 1'b0);
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
